// File: rtl/pwm_if.sv
// Control-side bundle between the PWM control block and the PWM generator.
// master: the control block, which issues ratio/direction requests.
// slave: the generator, which returns completion, the waveform and the applied direction.
interface pwm_if;
   logic       pwm_enable;
   logic [7:0] pwm_ratio;
   logic       pwm_direction;
   logic       pwm_update;
   logic       pwm_done;
   logic       pwm_out;
   logic       pwm_dir_out;

   modport master (
      output pwm_enable, pwm_ratio, pwm_direction, pwm_update,
      input  pwm_done, pwm_out, pwm_dir_out
   );

   modport slave (
      input  pwm_enable, pwm_ratio, pwm_direction, pwm_update,
      output pwm_done, pwm_out, pwm_dir_out
   );
endinterface

// File: rtl/pwm_generator.sv
// Motor PWM generator. The duty is 8 bits out of 255, and one PWM period is CLK_DIV*255 clocks.
// Requested ratio changes take effect only at period boundaries, limited to RAMP_STEP per boundary.
// A direction reversal with nonzero drive first coasts for DEAD_PERIODS full periods.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | disabled; counters and applied ratio held at 0, output low
// RUN   | waveform active; pending requests applied at each boundary
// DEAD  | coasting after reversal; output low, dead_cnt counts boundaries
module pwm_generator #(
   parameter int unsigned CLK_DIV      = 20,
   parameter int unsigned DEAD_PERIODS = 2,
   parameter int unsigned RAMP_STEP    = 8
) (
   input  logic  clock,
   input  logic  reset,
   pwm_if.slave  pwm
);

   typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

   localparam logic [15:0] TICK_LAST = 16'(CLK_DIV - 1);
   localparam logic [3:0]  DEAD_INIT = 4'(DEAD_PERIODS);
   localparam logic [8:0]  STEP      = 9'(RAMP_STEP);

   state_t      state;
   logic [15:0] tick_cnt;
   logic [7:0]  pcnt;
   logic [7:0]  active_ratio;
   logic        active_dir;
   logic [7:0]  pending_ratio;
   logic        pending_dir;
   logic        pending;
   logic [3:0]  dead_cnt;

   logic        tick;
   logic        boundary;
   logic [8:0]  ramp_up;
   logic [8:0]  ramp_dn_floor;
   logic [7:0]  stepped;

   assign tick     = (tick_cnt == TICK_LAST);
   assign boundary = tick && (pcnt == 8'd254);

   // One ramp step from the applied ratio toward the pending target, clamped at the target.
   // The 9-bit sums keep the comparisons from wrapping at either end of the 0..255 range.
   always_comb begin
      ramp_up       = {1'b0, active_ratio} + STEP;
      ramp_dn_floor = {1'b0, pending_ratio} + STEP;
      stepped       = pending_ratio;
      if (pending_ratio > active_ratio) begin
         if (ramp_up < {1'b0, pending_ratio}) begin
            stepped = ramp_up[7:0];
         end
      end else if ({1'b0, active_ratio} > ramp_dn_floor) begin
         stepped = active_ratio - STEP[7:0];
      end
   end

   // Sequencing FSM with the prescaler, the period counter, update capture and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         tick_cnt        <= '0;
         pcnt            <= '0;
         active_ratio    <= '0;
         active_dir      <= 1'b0;
         pending_ratio   <= '0;
         pending_dir     <= 1'b0;
         pending         <= 1'b0;
         dead_cnt        <= '0;
         pwm.pwm_done    <= 1'b0;
         pwm.pwm_out     <= 1'b0;
         pwm.pwm_dir_out <= 1'b0;
      end else begin
         pwm.pwm_done    <= 1'b0;
         pwm.pwm_out     <= (state == RUN) && (pcnt < active_ratio);
         pwm.pwm_dir_out <= active_dir;

         if (!pwm.pwm_enable) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            pcnt         <= '0;
            active_ratio <= '0;
         end else if (state == IDLE) begin
            state    <= RUN;
            tick_cnt <= '0;
            pcnt     <= '0;
         end else begin
            if (tick) begin
               tick_cnt <= '0;
               pcnt     <= (pcnt == 8'd254) ? 8'd0 : pcnt + 8'd1;
            end else begin
               tick_cnt <= tick_cnt + 16'd1;
            end

            if (boundary) begin
               if (state == DEAD) begin
                  dead_cnt <= dead_cnt - 4'd1;
                  if (dead_cnt == 4'd1) begin
                     state      <= RUN;
                     active_dir <= pending_dir;
                  end
               end else if (pending) begin
                  if ((pending_dir != active_dir) && (active_ratio != 8'd0)) begin
                     active_ratio <= '0;
                     dead_cnt     <= DEAD_INIT;
                     state        <= DEAD;
                  end else begin
                     active_dir   <= pending_dir;
                     active_ratio <= stepped;
                     if (stepped == pending_ratio) begin
                        pending      <= 1'b0;
                        pwm.pwm_done <= 1'b1;
                     end
                  end
               end
            end
         end

         // A fresh request wins over a completion clear on the same edge.
         if (pwm.pwm_update) begin
            pending       <= 1'b1;
            pending_ratio <= pwm.pwm_ratio;
            pending_dir   <= pwm.pwm_direction;
         end
      end
   end

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator. Two instances share one stimulus: dut_a has no ramp limit and dut_b has RAMP_STEP=8.
// Each PWM period is checked against a period-level reference model.
// Directed tables, hand-written sequences and random requests drive both instances.
module tb_pwm_generator;

   localparam int CLK_DIV = 2;
   localparam int DEAD_P  = 2;
   localparam int PERIOD  = CLK_DIV * 255;

   logic       clock  = 1'b0;
   logic       reset  = 1'b1;
   logic       enable = 1'b0;
   logic       update = 1'b0;
   logic       dir    = 1'b0;
   logic [7:0] ratio  = 8'd0;

   int n_cmp = 0;
   int n_bad = 0;

   pwm_if ia ();
   pwm_if ib ();

   assign ia.pwm_enable = enable;  assign ib.pwm_enable = enable;
   assign ia.pwm_ratio = ratio;    assign ib.pwm_ratio = ratio;
   assign ia.pwm_direction = dir;  assign ib.pwm_direction = dir;
   assign ia.pwm_update = update;  assign ib.pwm_update = update;

   wire [1:0] o_out  = {ib.pwm_out, ia.pwm_out};
   wire [1:0] o_done = {ib.pwm_done, ia.pwm_done};
   wire [1:0] o_dir  = {ib.pwm_dir_out, ia.pwm_dir_out};

   pwm_generator #(.CLK_DIV(CLK_DIV), .DEAD_PERIODS(DEAD_P), .RAMP_STEP(255)) dut_a (
      .clock(clock), .reset(reset), .pwm(ia.slave));
   pwm_generator #(.CLK_DIV(CLK_DIV), .DEAD_PERIODS(DEAD_P), .RAMP_STEP(8)) dut_b (
      .clock(clock), .reset(reset), .pwm(ib.slave));

   always #5 clock = ~clock;

   // period-level reference model, one slot per instance
   int m_ratio[2], m_dir[2], m_pend[2], m_pratio[2], m_pdir[2], m_dead[2], m_dcnt[2], m_done[2];
   int last_hi[2], last_dn[2], last_dir[2];

   typedef struct {
      int u1, r1, d1, u2, r2, d2;
      int hi, dn, dr;
   } vec_t;
   vec_t tbl[20];

   int ramp_hi[11] = '{0, 16, 32, 48, 64, 80, 64, 48, 32, 16, 6};
   int ramp_dn[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

   function automatic int step_of(input int d);
      return (d == 0) ? 255 : 8;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_ratio[d] = 0; m_dir[d] = 0; m_pend[d] = 0; m_pratio[d] = 0;
         m_pdir[d] = 0; m_dead[d] = 0; m_dcnt[d] = 0; m_done[d] = 0;
      end
   endtask

   task automatic model_update(input int r, input int dr);
      for (int d = 0; d < 2; d++) begin
         m_pend[d] = 1; m_pratio[d] = r; m_pdir[d] = dr;
      end
   endtask

   task automatic model_disable();
      for (int d = 0; d < 2; d++) begin
         m_ratio[d] = 0; m_dead[d] = 0;
      end
   endtask

   task automatic model_boundary();
      for (int d = 0; d < 2; d++) begin
         m_done[d] = 0;
         if (m_dead[d] != 0) begin
            m_dcnt[d]--;
            if (m_dcnt[d] == 0) begin
               m_dead[d] = 0;
               m_dir[d]  = m_pdir[d];
            end
         end else if (m_pend[d] != 0) begin
            if (m_pdir[d] != m_dir[d] && m_ratio[d] != 0) begin
               m_ratio[d] = 0; m_dead[d] = 1; m_dcnt[d] = DEAD_P;
            end else begin
               m_dir[d] = m_pdir[d];
               if (m_pratio[d] > m_ratio[d])
                  m_ratio[d] = (m_ratio[d] + step_of(d) < m_pratio[d]) ? m_ratio[d] + step_of(d) : m_pratio[d];
               else
                  m_ratio[d] = (m_ratio[d] - step_of(d) > m_pratio[d]) ? m_ratio[d] - step_of(d) : m_pratio[d];
               if (m_ratio[d] == m_pratio[d]) begin
                  m_pend[d] = 0; m_done[d] = 1;
               end
            end
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; enable = 1'b0; update = 1'b0; ratio = 8'd0; dir = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic enable_on();
      @(negedge clock);
      enable = 1'b1;
      @(posedge clock);
      #1;
   endtask

   // One full PWM period aligned to the boundaries.
   // Up to two requests are issued at clock offsets u1/u2 (0 = none); offset PERIOD lands on the closing boundary.
   task automatic run_window(input int u1, input int r1, input int d1,
                             input int u2, input int r2, input int d2);
      int exp_ratio[2], exp_dir[2], hi[2], dn[2], bad[2], dir_s[2];
      for (int d = 0; d < 2; d++) begin
         exp_ratio[d] = m_ratio[d]; exp_dir[d] = m_dir[d];
         hi[d] = 0; dn[d] = 0; bad[d] = 0; dir_s[d] = 0; m_done[d] = 0;
      end
      for (int k = 1; k <= PERIOD; k++) begin
         @(negedge clock);
         if (k == u1) begin
            ratio = 8'(r1); dir = 1'(d1); update = 1'b1;
         end else if (k == u2) begin
            ratio = 8'(r2); dir = 1'(d2); update = 1'b1;
         end
         @(posedge clock);
         if (k == PERIOD) model_boundary();
         if (update) model_update(int'(ratio), int'(dir));
         #1;
         update = 1'b0;
         for (int d = 0; d < 2; d++) begin
            if (int'(o_out[d]) != ((((k - 1) / CLK_DIV) < exp_ratio[d]) ? 1 : 0)) bad[d]++;
            hi[d]    += int'(o_out[d]);
            dn[d]    += int'(o_done[d]);
            dir_s[d]  = int'(o_dir[d]);
         end
      end
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("wave_%0d", d), bad[d], 0);
         chk($sformatf("high_%0d", d), hi[d], 2 * exp_ratio[d]);
         chk($sformatf("done_%0d", d), dn[d], m_done[d]);
         chk($sformatf("dir_%0d", d), dir_s[d], exp_dir[d]);
         last_hi[d] = hi[d]; last_dn[d] = dn[d]; last_dir[d] = dir_s[d];
      end
   endtask

   // Run k = 1..n of a period with an optional single request at offset u.
   task automatic partial_window(input int n, input int u, input int r, input int dr);
      for (int k = 1; k <= n; k++) begin
         @(negedge clock);
         if (k == u) begin
            ratio = 8'(r); dir = 1'(dr); update = 1'b1;
         end
         @(posedge clock);
         if (update) model_update(r, dr);
         #1;
         update = 1'b0;
      end
   endtask

   initial begin
      int cnt;
      int u1, r1, d1, u2, r2, d2, cur_dir;

      //              u1  r1  d1   u2  r2 d2   hi  dn dr
      tbl[0]  = '{100, 128, 0,   0,  0, 0,    0, 1, 0};
      tbl[1]  = '{  0,   0, 0,   0,  0, 0,  256, 0, 0};
      tbl[2]  = '{ 50,   0, 0,   0,  0, 0,  256, 1, 0};
      tbl[3]  = '{  0,   0, 0,   0,  0, 0,    0, 0, 0};
      tbl[4]  = '{ 50, 255, 0,   0,  0, 0,    0, 1, 0};
      tbl[5]  = '{  0,   0, 0,   0,  0, 0,  510, 0, 0};
      tbl[6]  = '{200, 100, 0,   0,  0, 0,  510, 1, 0};
      tbl[7]  = '{300, 100, 1,   0,  0, 0,  200, 0, 0};
      tbl[8]  = '{  0,   0, 0,   0,  0, 0,    0, 0, 0};
      tbl[9]  = '{  0,   0, 0,   0,  0, 0,    0, 0, 0};
      tbl[10] = '{  0,   0, 0,   0,  0, 0,    0, 1, 1};
      tbl[11] = '{  0,   0, 0,   0,  0, 0,  200, 0, 1};
      tbl[12] = '{ 50,   0, 1,   0,  0, 0,  200, 1, 1};
      tbl[13] = '{ 50,   0, 0,   0,  0, 0,    0, 1, 1};
      tbl[14] = '{ 50,  60, 0,   0,  0, 0,    0, 1, 0};
      tbl[15] = '{100,  50, 0, 300, 70, 0,  120, 1, 0};
      tbl[16] = '{  0,   0, 0,   0,  0, 0,  140, 0, 0};
      tbl[17] = '{100,  20, 0, 510, 90, 0,  140, 1, 0};
      tbl[18] = '{  0,   0, 0,   0,  0, 0,   40, 1, 0};
      tbl[19] = '{  0,   0, 0,   0,  0, 0,  180, 0, 0};

      // reset state with the generator disabled
      do_reset();
      repeat (3) @(posedge clock);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_out_%0d", d), int'(o_out[d]), 0);
         chk($sformatf("rst_done_%0d", d), int'(o_done[d]), 0);
         chk($sformatf("rst_dir_%0d", d), int'(o_dir[d]), 0);
      end

      // directed table: duty, reversal, overwrite and boundary coincidence
      enable_on();
      for (int i = 0; i < 20; i++) begin
         run_window(tbl[i].u1, tbl[i].r1, tbl[i].d1, tbl[i].u2, tbl[i].r2, tbl[i].d2);
         chk($sformatf("tbl%0d_high", i), last_hi[0], tbl[i].hi);
         chk($sformatf("tbl%0d_done", i), last_dn[0], tbl[i].dn);
         chk($sformatf("tbl%0d_dir", i), last_dir[0], tbl[i].dr);
      end

      // ramp 0 -> 40 -> 3 on the rate-limited instance
      do_reset();
      enable_on();
      for (int w = 0; w < 11; w++) begin
         if (w == 0)      run_window(100, 40, 0, 0, 0, 0);
         else if (w == 5) run_window(100, 3, 0, 0, 0, 0);
         else             run_window(0, 0, 0, 0, 0, 0);
         chk($sformatf("ramp%0d_high", w), last_hi[1], ramp_hi[w]);
         chk($sformatf("ramp%0d_done", w), last_dn[1], ramp_dn[w]);
      end

      // random requests against the model
      do_reset();
      enable_on();
      cur_dir = 0;
      for (int w = 0; w < 30; w++) begin
         u1 = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(PERIOD, 1));
         r1 = ($urandom_range(3, 0) == 0) ? (($urandom_range(1, 0) == 0) ? 0 : 255) : int'($urandom_range(255, 0));
         if ($urandom_range(4, 0) == 0) cur_dir = 1 - cur_dir;
         d1 = cur_dir;
         u2 = 0; r2 = 0; d2 = cur_dir;
         case ($urandom_range(7, 0))
            0: u2 = PERIOD;
            1: u2 = int'($urandom_range(PERIOD, 1));
            default: u2 = 0;
         endcase
         if (u2 != 0) r2 = int'($urandom_range(255, 0));
         run_window(u1, r1, d1, u2, r2, d2);
      end

      // disable mid-high-phase, pending request survives IDLE
      do_reset();
      enable_on();
      run_window(100, 255, 0, 0, 0, 0);
      partial_window(100, 50, 10, 0);
      chk("dis_pre_out_a", int'(o_out[0]), 1);
      @(negedge clock);
      enable = 1'b0;
      cnt = 0;
      @(posedge clock);
      #1;
      cnt += int'(o_done[0]) + int'(o_done[1]);
      @(posedge clock);
      #1;
      chk("dis_out_a", int'(o_out[0]), 0);
      chk("dis_out_b", int'(o_out[1]), 0);
      for (int k = 0; k < 20; k++) begin
         @(posedge clock);
         #1;
         cnt += int'(o_done[0]) + int'(o_done[1]) + int'(o_out[0]) + int'(o_out[1]);
      end
      chk("dis_quiet", cnt, 0);
      model_disable();
      enable_on();
      run_window(0, 0, 0, 0, 0, 0);
      chk("reen_done_a", last_dn[0], 1);
      run_window(0, 0, 0, 0, 0, 0);
      chk("reen_high_a", last_hi[0], 20);

      // asynchronous reset while coasting after a 1 -> 0 reversal
      do_reset();
      enable_on();
      run_window(100, 30, 1, 0, 0, 0);
      run_window(100, 30, 0, 0, 0, 0);
      partial_window(200, 0, 0, 0);
      chk("dead_pre_dir_a", int'(o_dir[0]), 1);
      chk("dead_pre_dir_b", int'(o_dir[1]), 1);
      #2;
      reset = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("arst_out_%0d", d), int'(o_out[d]), 0);
         chk($sformatf("arst_dir_%0d", d), int'(o_dir[d]), 0);
         chk($sformatf("arst_done_%0d", d), int'(o_done[d]), 0);
      end
      enable = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clock);
         #1;
         cnt += int'(o_done[0]) + int'(o_done[1]) + int'(o_dir[0]) + int'(o_dir[1]);
      end
      chk("arst_quiet", cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
